param_fifo: RTL
===============

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL be a parameter DATA_W, default 8, giving the data word width in bits.
REQ-002 The block SHALL be a parameter DEPTH, default 16, giving the entry count; it must be a power of two, at least 4.
REQ-003 The block SHALL be a parameter AF_LEVEL, default DEPTH-2, giving the almost_full assert level (count >= AF_LEVEL).
REQ-004 The block SHALL be a parameter AE_LEVEL, default 2, giving the almost_empty assert level (count <= AE_LEVEL).
REQ-005 Port clk SHALL be an input, 1 bit wide: the single clock, with all state on its rising edge.
REQ-006 Port rst SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-007 Port we SHALL be an input, 1 bit wide: the write request.
REQ-008 Port re SHALL be an input, 1 bit wide: the read request.
REQ-009 Port data_in SHALL be an input, DATA_W bits wide: the write data.
REQ-010 Port data_out SHALL be an output, DATA_W bits wide: the registered read data.
REQ-011 Ports full and empty SHALL be outputs, 1 bit each: the occupancy flags.
REQ-012 Ports almost_full and almost_empty SHALL be outputs, 1 bit each: the threshold flags.
REQ-013 Port count SHALL be an output, $clog2(DEPTH)+1 bits wide: the current occupancy, 0..DEPTH.

Function
REQ-014 A write is accepted when we=1 and (full=0, or re=1 with empty=0); data_in is stored at the write pointer, and the write pointer increments.
REQ-015 A read is accepted when re=1 and empty=0; the entry at the read pointer loads into data_out on the same edge, and the read pointer increments (read latency 1 cycle).
REQ-016 data_out SHALL hold its value on any cycle with no accepted read.
REQ-017 Pointers SHALL be $clog2(DEPTH) bits wide and wrap DEPTH-1 -> 0 without a gap.
REQ-018 count SHALL update by +1 (write only), -1 (read only), or 0 (both or neither), registered.
REQ-019 full, empty, almost_full and almost_empty SHALL be decoded from registered count: full = (count==DEPTH), empty = (count==0).
REQ-020 When full, simultaneous we and re SHALL both be accepted; count stays DEPTH.
REQ-021 When empty, simultaneous we and re SHALL accept the write only; the read is ignored, and data_out holds.
REQ-022 We when full without re, and re when empty, SHALL be ignored with no state change.

Reset
REQ-023 When rst=0, pointers and count SHALL clear immediately, and data_out SHALL clear to 0.
REQ-024 When rst=0, the outputs SHALL take these values: empty=1, almost_empty=1, full=0, almost_full=0.
REQ-025 Memory contents SHALL NOT be reset; reset mid-operation discards all stored entries.

Configuration
REQ-026 When macro PARAM_FIFO_ERR_FLAGS_EN is defined, the block SHALL add outputs overflow and underflow, 1 bit each.
REQ-027 The overflow and underflow outputs SHALL be sticky: set on a rejected write or read respectively, and cleared only by reset.
REQ-028 When PARAM_FIFO_ERR_FLAGS_EN is undefined, the ports and logic SHALL be absent, and the remaining behaviour SHALL be unchanged.

Structure
REQ-029 Shared package param_fifo_pkg SHALL hold the default DATA_W/DEPTH constants and the pointer-width helper function.
REQ-030 Storage SHALL be sub-module fifo_ram: DEPTH x DATA_W, with one synchronous write port and one synchronous read port, and no reset.

Verification
REQ-031 Reset, then 16 writes of 0x00..0x0F (defaults): full=1 after the 16th edge, almost_full=1 from count=14, and count=16.
REQ-032 Read 16 entries from full: data_out = 0x00..0x0F in order, each one cycle after re; empty=1 after the last, almost_empty=1 from count=2.
REQ-033 Write 0xAA with re=1 while full: count stays 16, the oldest word appears on data_out, and 0xAA is stored; 20 mixed operations verify pointer wrap order.
REQ-034 re=1 on empty with we=1 and data 0x55: count=1, and data_out is unchanged; the next read returns 0x55.
REQ-035 Write 3 words, assert rst=0 asynchronously mid-cycle: count=0 and empty=1 before the next edge, and a subsequent read is ignored.
REQ-036 With PARAM_FIFO_ERR_FLAGS_EN defined: a write with we=1 while full and re=0 sets overflow=1, and a read while empty sets underflow=1; both persist until rst=0.

Source files
------------

// File: rtl/param_fifo_pkg.sv
// param_fifo_pkg: shared constants and helpers for the param_fifo slice.
// Holds default word width / depth and the pointer-width helper.
package param_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    // Pointer width for a power-of-two depth; never narrower than 1 bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_W storage, one sync write port, one sync read port.
// Ports: clk, wr_en/wr_addr/wr_data, rd_en/rd_addr -> rd_data (1-cycle, held).
module fifo_ram
    import param_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = ptr_w(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-before-write: a read and write to the same address on one edge
    // returns the old word, which is what a full FIFO read+write needs.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/param_fifo.sv
// param_fifo: synchronous FIFO with registered read data and level flags.
// Ports: clk, rst (async, active-low), we/re, data_in -> data_out,
//   full/empty, almost_full/almost_empty, count (0..DEPTH).
// Optional: PARAM_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic                       re,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    ,
    output logic                       overflow,
    output logic                       underflow
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic              rd_seen;
    logic [DATA_W-1:0] ram_q;

    assign full         = (count == FULL_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A full FIFO still takes a write when a read frees a slot the same edge.
    assign rd_acc = re && !empty;
    assign wr_acc = we && (!full || rd_acc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The RAM read register has no reset, so data_out is forced to zero
    // until the first accepted read after reset reloads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_seen <= 1'b0;
        end else if (rd_acc) begin
            rd_seen <= 1'b1;
        end
    end

    assign data_out = rd_seen ? ram_q : '0;

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

`ifdef PARAM_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (we && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (re && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule
